// File: rtl/vending_machine_param.sv
// Parametrised vending controller: priced items with stock, saturating
// coin balance, buy/return handling and a fixed-length serial report.
module vending_machine_param #(
  parameter int N_ITEM    = 6,
  parameter int ITEM_W    = 3,
  parameter int PRICE_W   = 5,
  parameter int COIN_W    = 6,
  parameter int ACC_W     = 9,
  parameter int CNT_W     = 6,
  parameter int MAX_STOCK = 7,
  parameter int CONS_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_item_valid,
  input  logic [PRICE_W-1:0] in_item_price,
  input  logic               in_coin_valid,
  input  logic [COIN_W-1:0]  in_coin,
  input  logic               in_rtn_coin,
  input  logic [ITEM_W-1:0]  in_buy_item,
  output logic [ACC_W-1:0]   out_monitor,
  output logic               out_valid,
  output logic [CONS_W-1:0]  out_consumer,
  output logic [CNT_W-1:0]   out_sell_num
);

  localparam int RPT_L = (N_ITEM > 6) ? N_ITEM : 6;
  localparam int IDX_W = $clog2(RPT_L);
  localparam int STK_W = $clog2(MAX_STOCK + 1);
  localparam int LD_W  = $clog2(N_ITEM + 1);

  localparam logic [ACC_W-1:0] C50 = ACC_W'(50);
  localparam logic [ACC_W-1:0] C20 = ACC_W'(20);
  localparam logic [ACC_W-1:0] C10 = ACC_W'(10);
  localparam logic [ACC_W-1:0] C5  = ACC_W'(5);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COIN,
    REPORT
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0]   bal_q, bal_d;
  logic [ACC_W-1:0]   mon_q;
  logic [PRICE_W-1:0] price_q [N_ITEM];
  logic [STK_W-1:0]   stock_q [N_ITEM];
  logic [CNT_W-1:0]   sell_q  [N_ITEM];
  logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic [IDX_W-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic [CONS_W-1:0]  word_q [6];
  logic [CONS_W-1:0]  word_d [6];
  logic               valid_q;
  logic [CONS_W-1:0]  cons_q;
  logic [CNT_W-1:0]   selln_q;

  logic [LD_W-1:0]    ld_cnt_nxt;
  logic               ld_shift, ld_last;
  logic               coin_ev, req_ok, rtn_ev, buy_ev;
  logic               item_ok, buy_ok, sale, word_ld;
  logic [PRICE_W-1:0] sel_price;
  logic [STK_W-1:0]   sel_stock;
  logic [N_ITEM-1:0]  sale_vec;
  logic [ACC_W:0]     coin_sum;
  logic [ACC_W-1:0]   coin_bal;
  logic [ACC_W-1:0]   chg, r1, r2, r3, r4;
  logic [ACC_W-1:0]   n50, n20, n10, n5;
  logic [CONS_W-1:0]  rpt_cons;
  logic [CNT_W-1:0]   rpt_sell;

  assign coin_sum = {1'b0, bal_q} + (ACC_W + 1)'(in_coin);
  assign coin_bal = coin_sum[ACC_W] ? '1 : coin_sum[ACC_W-1:0];

  assign ld_shift   = in_item_valid &&
                      (state_q == IDLE || state_q == LOAD);
  assign ld_cnt_nxt = ((state_q == LOAD) ? ld_cnt_q : '0)
                      + LD_W'(1);
  assign ld_last    = ld_shift && (ld_cnt_nxt == LD_W'(N_ITEM));

  // A price-load strobe in IDLE takes precedence over a coin.
  assign coin_ev = in_coin_valid &&
                   (state_q == COIN ||
                    (state_q == IDLE && !in_item_valid));
  assign req_ok  = (state_q == COIN) && !in_coin_valid;
  assign rtn_ev  = req_ok && in_rtn_coin;
  assign buy_ev  = req_ok && !in_rtn_coin &&
                   (in_buy_item != '0);

  always_comb begin
    item_ok   = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int j = 0; j < N_ITEM; j++) begin
      if (in_buy_item == ITEM_W'(j + 1)) begin
        item_ok   = 1'b1;
        sel_price = price_q[j];
        sel_stock = stock_q[j];
      end
    end
  end

  assign buy_ok = item_ok && (sel_stock != '0) &&
                  (bal_q >= ACC_W'(sel_price));
  assign sale   = buy_ev && buy_ok;

  always_comb begin
    sale_vec = '0;
    for (int j = 0; j < N_ITEM; j++) begin
      sale_vec[j] = sale &&
                    (in_buy_item == ITEM_W'(j + 1));
    end
  end

  // Greedy change breakdown, latched when the report starts.
  always_comb begin
    chg = '0;
    if (rtn_ev) begin
      chg = bal_q;
    end else if (sale) begin
      chg = bal_q - ACC_W'(sel_price);
    end
    n50 = chg / C50;
    r1  = chg - n50 * C50;
    n20 = r1 / C20;
    r2  = r1 - n20 * C20;
    n10 = r2 / C10;
    r3  = r2 - n10 * C10;
    n5  = r3 / C5;
    r4  = r3 - n5 * C5;
    word_d[0] = sale ? CONS_W'(in_buy_item) : '0;
    word_d[1] = CONS_W'(n50);
    word_d[2] = CONS_W'(n20);
    word_d[3] = CONS_W'(n10);
    word_d[4] = CONS_W'(n5);
    word_d[5] = CONS_W'(r4);
  end

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    ld_cnt_d  = ld_shift ? ld_cnt_nxt : '0;
    rpt_cnt_d = '0;
    word_ld   = rtn_ev || buy_ev;
    if (coin_ev) begin
      bal_d = coin_bal;
    end else if (rtn_ev || sale) begin
      bal_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (ld_shift) begin
          state_d = ld_last ? IDLE : LOAD;
        end else if (coin_ev) begin
          state_d = COIN;
        end
      end
      LOAD: begin
        if (!in_item_valid || ld_last) begin
          state_d = IDLE;
        end
      end
      COIN: begin
        if (rtn_ev || buy_ev) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        rpt_cnt_d = rpt_cnt_q + IDX_W'(1);
        if (rpt_cnt_q == IDX_W'(RPT_L - 1)) begin
          state_d = (bal_q == '0) ? IDLE : COIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rpt_cons = '0;
    rpt_sell = '0;
    for (int j = 0; j < 6; j++) begin
      if (rpt_cnt_q == IDX_W'(j)) begin
        rpt_cons = word_q[j];
      end
    end
    for (int j = 0; j < N_ITEM; j++) begin
      if (rpt_cnt_q == IDX_W'(j)) begin
        rpt_sell = sell_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bal_q     <= '0;
      mon_q     <= '0;
      ld_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      valid_q   <= 1'b0;
      cons_q    <= '0;
      selln_q   <= '0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      mon_q     <= bal_q;
      ld_cnt_q  <= ld_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      valid_q   <= (state_q == REPORT);
      cons_q    <= (state_q == REPORT) ? rpt_cons : '0;
      selln_q   <= (state_q == REPORT) ? rpt_sell : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 6; j++) begin
        word_q[j] <= '0;
      end
    end else if (word_ld) begin
      for (int j = 0; j < 6; j++) begin
        word_q[j] <= word_d[j];
      end
    end
  end

  // Prices shift in from the top so the first strobe ends at item 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_ITEM; j++) begin
        price_q[j] <= '0;
        stock_q[j] <= '0;
        sell_q[j]  <= '0;
      end
    end else begin
      if (ld_shift) begin
        price_q[N_ITEM-1] <= in_item_price;
        for (int j = 0; j < N_ITEM - 1; j++) begin
          price_q[j] <= price_q[j+1];
        end
      end
      for (int j = 0; j < N_ITEM; j++) begin
        if (ld_last) begin
          stock_q[j] <= STK_W'(MAX_STOCK);
          sell_q[j]  <= '0;
        end else if (sale_vec[j]) begin
          stock_q[j] <= stock_q[j] - STK_W'(1);
          if (sell_q[j] != '1) begin
            sell_q[j] <= sell_q[j] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign out_monitor  = mon_q;
  assign out_valid    = valid_q;
  assign out_consumer = cons_q;
  assign out_sell_num = selln_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: load, buy, sold-out,
// saturation, request priority and mid-report reset.
module tb_vending_machine_param;

  localparam int L = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_item_valid = 1'b0;
  logic [4:0] in_item_price = '0;
  logic       in_coin_valid = 1'b0;
  logic [5:0] in_coin = '0;
  logic       in_rtn_coin = 1'b0;
  logic [2:0] in_buy_item = '0;
  logic [8:0] out_monitor;
  logic       out_valid;
  logic [3:0] out_consumer;
  logic [5:0] out_sell_num;

  int pass_n = 0;
  int total_n = 0;

  always #5 clk = ~clk;

  vending_machine_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_item_valid(in_item_valid),
    .in_item_price(in_item_price),
    .in_coin_valid(in_coin_valid),
    .in_coin      (in_coin),
    .in_rtn_coin  (in_rtn_coin),
    .in_buy_item  (in_buy_item),
    .out_monitor  (out_monitor),
    .out_valid    (out_valid),
    .out_consumer (out_consumer),
    .out_sell_num (out_sell_num)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prices();
    int p[6] = '{3, 4, 5, 6, 7, 8};
    for (int i = 0; i < 6; i++) begin
      in_item_valid = 1'b1;
      in_item_price = 5'(p[i]);
      cyc();
    end
    in_item_valid = 1'b0;
    in_item_price = '0;
    cyc();
  endtask

  task automatic coin(input int v);
    in_coin_valid = 1'b1;
    in_coin = 6'(v);
    cyc();
    in_coin_valid = 1'b0;
    in_coin = '0;
  endtask

  task automatic buy(input int k);
    in_buy_item = 3'(k);
    cyc();
    in_buy_item = '0;
  endtask

  task automatic rtn();
    in_rtn_coin = 1'b1;
    cyc();
    in_rtn_coin = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    total_n++;
    if (out_valid !== 1'b0 || out_consumer !== 4'd0 ||
        out_sell_num !== 6'd0 || out_monitor !== 9'd0)
      $display("FAIL reset: v=%0b c=%0d s=%0d m=%0d, want 0/0/0/0",
               out_valid, out_consumer, out_sell_num, out_monitor);
    else pass_n++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_buy();
    int ec[6] = '{2, 1, 0, 1, 1, 1};
    int es[6] = '{0, 1, 0, 0, 0, 0};
    load_prices();
    coin(50);
    coin(20);
    cyc();
    total_n++;
    if (out_monitor !== 9'd70)
      $display("FAIL basic_mon: got %0d want 70", out_monitor);
    else pass_n++;
    buy(2);
    for (int i = 0; i < L; i++) begin
      cyc();
      total_n++;
      if (out_valid !== 1'b1 || out_consumer !== 4'(ec[i]) ||
          out_sell_num !== 6'(es[i]))
        $display("FAIL basic_rpt[%0d]: v=%0b c=%0d s=%0d, want 1/%0d/%0d",
                 i, out_valid, out_consumer, out_sell_num, ec[i], es[i]);
      else pass_n++;
    end
    cyc();
    total_n++;
    if (out_valid !== 1'b0 || out_consumer !== 4'd0 ||
        out_monitor !== 9'd0)
      $display("FAIL basic_end: v=%0b c=%0d m=%0d, want 0/0/0",
               out_valid, out_consumer, out_monitor);
    else pass_n++;
  endtask

  task automatic test_buy_fail();
    int cv[3] = '{10, 5, 0};
    int it[3] = '{6, 6, 0};
    int em[3] = '{0, 5, 0};
    int ec[3][6] = '{'{6, 0, 0, 0, 0, 2},
                     '{0, 0, 0, 0, 0, 0},
                     '{0, 0, 0, 0, 1, 0}};
    int es[6] = '{0, 1, 0, 0, 0, 1};
    for (int s = 0; s < 3; s++) begin
      if (cv[s] != 0) coin(cv[s]);
      if (it[s] != 0) buy(it[s]);
      else rtn();
      for (int i = 0; i < L; i++) begin
        cyc();
        total_n++;
        if (out_valid !== 1'b1 || out_consumer !== 4'(ec[s][i]) ||
            out_sell_num !== 6'(es[i]))
          $display("FAIL fail_rpt%0d[%0d]: v=%0b c=%0d s=%0d, want 1/%0d/%0d",
                   s, i, out_valid, out_consumer, out_sell_num,
                   ec[s][i], es[i]);
        else pass_n++;
      end
      cyc();
      total_n++;
      if (out_valid !== 1'b0 || out_monitor !== 9'(em[s]))
        $display("FAIL fail_end%0d: v=%0b m=%0d, want 0/%0d",
                 s, out_valid, out_monitor, em[s]);
      else pass_n++;
    end
  endtask

  task automatic test_sold_out();
    int w0, sn;
    load_prices();
    for (int n = 0; n < 8; n++) begin
      coin(4);
      buy(2);
      w0 = (n < 7) ? 2 : 0;
      sn = (n < 7) ? n + 1 : 7;
      for (int i = 0; i < L; i++) begin
        cyc();
        total_n++;
        if (out_valid !== 1'b1 ||
            out_consumer !== 4'((i == 0) ? w0 : 0) ||
            out_sell_num !== 6'((i == 1) ? sn : 0))
          $display("FAIL sold%0d[%0d]: v=%0b c=%0d s=%0d, want 1/%0d/%0d",
                   n, i, out_valid, out_consumer, out_sell_num,
                   (i == 0) ? w0 : 0, (i == 1) ? sn : 0);
        else pass_n++;
      end
      cyc();
    end
    total_n++;
    if (out_monitor !== 9'd4)
      $display("FAIL sold_keep: monitor %0d want 4", out_monitor);
    else pass_n++;
    rtn();
    for (int i = 0; i < L; i++) begin
      cyc();
      total_n++;
      if (out_consumer !== 4'((i == 5) ? 4 : 0) ||
          out_sell_num !== 6'((i == 1) ? 7 : 0))
        $display("FAIL sold_rtn[%0d]: c=%0d s=%0d, want %0d/%0d",
                 i, out_consumer, out_sell_num,
                 (i == 5) ? 4 : 0, (i == 1) ? 7 : 0);
      else pass_n++;
    end
    cyc();
  endtask

  task automatic test_saturate();
    int ec[6] = '{0, 10, 0, 1, 0, 1};
    for (int n = 0; n < 8; n++) coin(63);
    cyc();
    total_n++;
    if (out_monitor !== 9'd504)
      $display("FAIL sat_504: monitor %0d want 504", out_monitor);
    else pass_n++;
    coin(63);
    cyc();
    total_n++;
    if (out_monitor !== 9'd511)
      $display("FAIL sat_511: monitor %0d want 511", out_monitor);
    else pass_n++;
    rtn();
    for (int i = 0; i < L; i++) begin
      cyc();
      total_n++;
      if (out_valid !== 1'b1 || out_consumer !== 4'(ec[i]))
        $display("FAIL sat_rtn[%0d]: v=%0b c=%0d, want 1/%0d",
                 i, out_valid, out_consumer, ec[i]);
      else pass_n++;
    end
    cyc();
    total_n++;
    if (out_monitor !== 9'd0 || out_valid !== 1'b0)
      $display("FAIL sat_end: m=%0d v=%0b, want 0/0",
               out_monitor, out_valid);
    else pass_n++;
  endtask

  task automatic test_priority();
    int ec[6] = '{0, 0, 1, 1, 0, 0};
    coin(20);
    in_coin_valid = 1'b1;
    in_coin = 6'd10;
    in_buy_item = 3'd1;
    cyc();
    in_coin_valid = 1'b0;
    in_coin = '0;
    in_buy_item = '0;
    cyc();
    total_n++;
    if (out_valid !== 1'b0 || out_monitor !== 9'd30)
      $display("FAIL coin_buy: v=%0b m=%0d, want 0/30",
               out_valid, out_monitor);
    else pass_n++;
    buy(7);
    for (int i = 0; i < L; i++) begin
      cyc();
      total_n++;
      if (out_valid !== 1'b1 || out_consumer !== 4'd0 ||
          out_sell_num !== 6'((i == 1) ? 7 : 0))
        $display("FAIL invalid[%0d]: v=%0b c=%0d s=%0d, want 1/0/%0d",
                 i, out_valid, out_consumer, out_sell_num,
                 (i == 1) ? 7 : 0);
      else pass_n++;
    end
    cyc();
    total_n++;
    if (out_monitor !== 9'd30)
      $display("FAIL invalid_keep: monitor %0d want 30", out_monitor);
    else pass_n++;
    in_rtn_coin = 1'b1;
    in_buy_item = 3'd1;
    cyc();
    in_rtn_coin = 1'b0;
    in_buy_item = '0;
    for (int i = 0; i < L; i++) begin
      cyc();
      total_n++;
      if (out_valid !== 1'b1 || out_consumer !== 4'(ec[i]))
        $display("FAIL rtn_win[%0d]: v=%0b c=%0d, want 1/%0d",
                 i, out_valid, out_consumer, ec[i]);
      else pass_n++;
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int ec[3] = '{1, 0, 1};
    int es[3] = '{1, 7, 0};
    coin(30);
    buy(1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      total_n++;
      if (out_valid !== 1'b1 || out_consumer !== 4'(ec[i]) ||
          out_sell_num !== 6'(es[i]))
        $display("FAIL mid_rpt[%0d]: v=%0b c=%0d s=%0d, want 1/%0d/%0d",
                 i, out_valid, out_consumer, out_sell_num, ec[i], es[i]);
      else pass_n++;
    end
    rst_n = 1'b0;
    #1;
    total_n++;
    if (out_valid !== 1'b0 || out_consumer !== 4'd0 ||
        out_sell_num !== 6'd0 || out_monitor !== 9'd0)
      $display("FAIL mid_reset: v=%0b c=%0d s=%0d m=%0d, want 0/0/0/0",
               out_valid, out_consumer, out_sell_num, out_monitor);
    else pass_n++;
    cyc();
    rst_n = 1'b1;
    cyc();
    coin(10);
    buy(1);
    for (int i = 0; i < L; i++) begin
      cyc();
      total_n++;
      if (out_valid !== 1'b1 || out_consumer !== 4'd0 ||
          out_sell_num !== 6'd0)
        $display("FAIL post_rst[%0d]: v=%0b c=%0d s=%0d, want 1/0/0",
                 i, out_valid, out_consumer, out_sell_num);
      else pass_n++;
    end
    cyc();
    total_n++;
    if (out_valid !== 1'b0 || out_monitor !== 9'd10)
      $display("FAIL post_rst_end: v=%0b m=%0d, want 0/10",
               out_valid, out_monitor);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_basic_buy();
    test_buy_fail();
    test_sold_out();
    test_saturate();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
